// File: rtl/ram_arbiter.sv
// ram_arbiter: shares one single-port synchronous RAM between two requesters with latched access sequencing.
module ram_arbiter #(
  parameter int ADDR_W     = 16,
  parameter int DATA_W     = 8,
  parameter int RD_LAT     = 1,
  parameter int FIXED_PRIO = 0
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic [ADDR_W-1:0] i_p0_addr,
  input  logic [DATA_W-1:0] i_p0_wdata,
  input  logic              i_p0_read,
  input  logic              i_p0_write,
  output logic [DATA_W-1:0] o_p0_rdata,
  output logic              o_p0_done,
  input  logic [ADDR_W-1:0] i_p1_addr,
  input  logic [DATA_W-1:0] i_p1_wdata,
  input  logic              i_p1_read,
  input  logic              i_p1_write,
  output logic [DATA_W-1:0] o_p1_rdata,
  output logic              o_p1_done,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [DATA_W-1:0] o_mem_wdata,
  output logic              o_mem_we,
  output logic              o_mem_re,
  input  logic [DATA_W-1:0] i_mem_rdata,
  output logic [1:0]        o_grant,
  output logic              o_busy
);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;
  state_t            state_q;
  logic              last_q, win_q, win_d, req0, req1;
  logic [2:0]        cnt_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q, rdata0_q, rdata1_q;
  logic              we_q, re_q, done0_q, done1_q, busy_q;
  logic [1:0]        grant_q;
  always_comb begin
    req0  = i_p0_read | i_p0_write;
    req1  = i_p1_read | i_p1_write;
    win_d = (req0 && req1) ? ((FIXED_PRIO != 0) ? 1'b0 : ~last_q) : req1;
  end
  // The latched access lives directly in the RAM-facing registers, which are cleared every cycle except ISSUE.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q  <= IDLE;
      last_q   <= 1'b1;
      win_q    <= 1'b0;
      cnt_q    <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      we_q     <= 1'b0;
      re_q     <= 1'b0;
      done0_q  <= 1'b0;
      done1_q  <= 1'b0;
      rdata0_q <= '0;
      rdata1_q <= '0;
      grant_q  <= '0;
      busy_q   <= 1'b0;
    end else begin
      addr_q  <= '0;
      wdata_q <= '0;
      we_q    <= 1'b0;
      re_q    <= 1'b0;
      done0_q <= 1'b0;
      done1_q <= 1'b0;
      case (state_q)
        IDLE: if (req0 || req1) begin
          state_q <= ISSUE;
          win_q   <= win_d;
          last_q  <= win_d;
          grant_q <= win_d ? 2'b10 : 2'b01;
          busy_q  <= 1'b1;
          addr_q  <= win_d ? i_p1_addr : i_p0_addr;
          wdata_q <= win_d ? i_p1_wdata : i_p0_wdata;
          we_q    <= win_d ? i_p1_write : i_p0_write;
          re_q    <= win_d ? ~i_p1_write : ~i_p0_write;
        end
        ISSUE: begin
          state_q <= we_q ? DONE : WAIT;
          cnt_q   <= 3'(RD_LAT - 1);
          done0_q <= we_q & ~win_q;
          done1_q <= we_q & win_q;
        end
        WAIT: if (cnt_q == 3'd0) begin
          state_q <= DONE;
          done0_q <= ~win_q;
          done1_q <= win_q;
          if (win_q) rdata1_q <= i_mem_rdata;
          else rdata0_q <= i_mem_rdata;
        end else cnt_q <= cnt_q - 3'd1;
        DONE: begin
          state_q <= IDLE;
          grant_q <= '0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end
  assign o_mem_addr  = addr_q;
  assign o_mem_wdata = wdata_q;
  assign o_mem_we    = we_q;
  assign o_mem_re    = re_q;
  assign o_p0_done   = done0_q;
  assign o_p1_done   = done1_q;
  assign o_p0_rdata  = rdata0_q;
  assign o_p1_rdata  = rdata1_q;
  assign o_grant     = grant_q;
  assign o_busy      = busy_q;
endmodule

// File: tb/tb_ram_arbiter.sv
// tb_ram_arbiter: directed checks of a round-robin RD_LAT=2 arbiter and a fixed-priority RD_LAT=1 arbiter sharing stimulus.
module tb_ram_arbiter;
  logic        clk = 1'b0, rst_n = 1'b0;
  logic [15:0] p0_addr = '0, p1_addr = '0;
  logic [7:0]  p0_wdata = '0, p1_wdata = '0, mem_rdata = 8'hEE;
  logic        p0_read = 1'b0, p0_write = 1'b0, p1_read = 1'b0, p1_write = 1'b0;
  logic [7:0]  r_p0_rdata, r_p1_rdata, r_mem_wdata, f_p0_rdata, f_p1_rdata, f_mem_wdata;
  logic [15:0] r_mem_addr, f_mem_addr;
  logic        r_p0_done, r_p1_done, r_we, r_re, r_busy, f_p0_done, f_p1_done, f_we, f_re, f_busy;
  logic [1:0]  r_grant, f_grant;
  int checks = 0, failures = 0;
  always #5 clk = ~clk;
  ram_arbiter #(.ADDR_W(16), .DATA_W(8), .RD_LAT(2), .FIXED_PRIO(0)) u_rr (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_p0_addr(p0_addr), .i_p0_wdata(p0_wdata), .i_p0_read(p0_read), .i_p0_write(p0_write),
    .o_p0_rdata(r_p0_rdata), .o_p0_done(r_p0_done),
    .i_p1_addr(p1_addr), .i_p1_wdata(p1_wdata), .i_p1_read(p1_read), .i_p1_write(p1_write),
    .o_p1_rdata(r_p1_rdata), .o_p1_done(r_p1_done),
    .o_mem_addr(r_mem_addr), .o_mem_wdata(r_mem_wdata), .o_mem_we(r_we), .o_mem_re(r_re),
    .i_mem_rdata(mem_rdata), .o_grant(r_grant), .o_busy(r_busy));
  ram_arbiter #(.ADDR_W(16), .DATA_W(8), .RD_LAT(1), .FIXED_PRIO(1)) u_fp (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_p0_addr(p0_addr), .i_p0_wdata(p0_wdata), .i_p0_read(p0_read), .i_p0_write(p0_write),
    .o_p0_rdata(f_p0_rdata), .o_p0_done(f_p0_done),
    .i_p1_addr(p1_addr), .i_p1_wdata(p1_wdata), .i_p1_read(p1_read), .i_p1_write(p1_write),
    .o_p1_rdata(f_p1_rdata), .o_p1_done(f_p1_done),
    .o_mem_addr(f_mem_addr), .o_mem_wdata(f_mem_wdata), .o_mem_we(f_we), .o_mem_re(f_re),
    .i_mem_rdata(mem_rdata), .o_grant(f_grant), .o_busy(f_busy));
  task automatic step(int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask
  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic do_reset();
    rst_n = 1'b0;
    {p0_read, p0_write, p1_read, p1_write} = '0;
    step(2);
    rst_n = 1'b1;
  endtask
  initial begin
    do_reset();
    chk("rst_busy", r_busy, 0);
    chk("rst_grant", r_grant, 0);
    chk("rst_strobes", {r_we, r_re, r_p0_done, r_p1_done}, 0);
    chk("rst_rdata", {r_p0_rdata, r_p1_rdata}, 0);
    chk("rst_mem_addr", r_mem_addr, 0);
    // test 1: p0 write
    p0_addr = 16'h0005; p0_wdata = 8'hA5; p0_write = 1'b1;
    step();
    chk("t1_we", {r_we, r_re}, 2'b10);
    chk("t1_addr", r_mem_addr, 16'h0005);
    chk("t1_wdata", r_mem_wdata, 8'hA5);
    chk("t1_grant", r_grant, 2'b01);
    chk("t1_busy", r_busy, 1);
    p0_write = 1'b0;
    step();
    chk("t1_done", {r_p0_done, r_p1_done}, 2'b10);
    chk("t1_rdata", r_p0_rdata, 0);
    chk("t1_mem_idle", {r_we, r_re, r_mem_addr}, 0);
    step();
    chk("t1_idle", {r_busy, r_grant, r_p0_done}, 0);
    // test 2: p0 read, RD_LAT=2, data valid only in the capture cycle
    p0_addr = 16'h0010; p0_read = 1'b1;
    step();
    chk("t2_re", {r_we, r_re}, 2'b01);
    chk("t2_addr", r_mem_addr, 16'h0010);
    p0_read = 1'b0;
    step();
    chk("t2_wait_done", r_p0_done, 0);
    step();
    mem_rdata = 8'h3C;
    chk("t2_wait2_done", r_p0_done, 0);
    step();
    mem_rdata = 8'hEE;
    chk("t2_done", {r_p0_done, r_p1_done}, 2'b10);
    chk("t2_rdata", r_p0_rdata, 8'h3C);
    step();
    chk("t2_hold", {r_p0_done, r_p0_rdata}, {1'b0, 8'h3C});
    // test 6: p1 read+write is a write
    p1_addr = 16'h0020; p1_wdata = 8'h77; p1_read = 1'b1; p1_write = 1'b1;
    step();
    chk("t6_strobes", {r_we, r_re}, 2'b10);
    chk("t6_wdata", r_mem_wdata, 8'h77);
    chk("t6_grant", r_grant, 2'b10);
    p1_read = 1'b0; p1_write = 1'b0;
    step();
    chk("t6_done", {r_p0_done, r_p1_done}, 2'b01);
    chk("t6_rdata", {r_p1_rdata, r_p0_rdata}, {8'h00, 8'h3C});
    // test 3: round-robin with both ports holding reads
    do_reset();
    mem_rdata = 8'h5A;
    p0_addr = 16'h0001; p1_addr = 16'h0002; p0_read = 1'b1; p1_read = 1'b1;
    for (int k = 0; k < 4; k++) begin
      step();
      chk($sformatf("t3_grant%0d", k), r_grant, (k % 2 == 0) ? 2'b01 : 2'b10);
      chk($sformatf("t3_addr%0d", k), r_mem_addr, (k % 2 == 0) ? 16'h0001 : 16'h0002);
      step(3);
      chk($sformatf("t3_done%0d", k), {r_p0_done, r_p1_done}, (k % 2 == 0) ? 2'b10 : 2'b01);
      if (k == 0) chk("t3_p1_rdata_untouched", r_p1_rdata, 0);
      step();
    end
    // test 4: fixed priority starves p1 while p0 keeps requesting
    do_reset();
    p0_write = 1'b1; p1_read = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      chk($sformatf("t4_grant%0d", k), f_grant, 2'b01);
      step();
      chk($sformatf("t4_done%0d", k), {f_p0_done, f_p1_done}, 2'b10);
      if (k == 2) p0_write = 1'b0;
      step();
    end
    step();
    chk("t4_p1_grant", f_grant, 2'b10);
    chk("t4_p1_re", {f_we, f_re}, 2'b01);
    p1_read = 1'b0;
    step(2);
    chk("t4_p1_done", {f_p0_done, f_p1_done}, 2'b01);
    // test 5: reset during WAIT abandons the read
    do_reset();
    mem_rdata = 8'h99;
    p0_read = 1'b1;
    step(2);
    chk("t5_in_wait", {r_busy, r_re}, 2'b10);
    rst_n = 1'b0;
    step();
    chk("t5_busy", r_busy, 0);
    chk("t5_outputs", {r_grant, r_we, r_re, r_p0_done, r_p1_done, r_p0_rdata, r_mem_addr}, 0);
    rst_n = 1'b1; p0_read = 1'b0;
    step(3);
    chk("t5_no_done", {r_p0_done, r_p0_rdata, r_busy}, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
